// File: rtl/drive_sequencer.sv
// drive_sequencer: programmable replay of a small table of drive entries.
// A test controller loads the table through CFG_*, starts a run with START.
// Each entry then appears as a one-cycle DRIV pulse carrying its shift, front
// and data fields. Entries are separated by a per-entry idle gap. The whole
// table can be repeated LOOP_CNT extra times. All outputs are registered.
// Each output already shows the values of the cycle it belongs to.

module drive_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CFG_WE,
    input  logic [AW-1:0] CFG_ADDR,
    input  logic [23:0]   CFG_DATA,
    input  logic [7:0]    LOOP_CNT,
    input  logic          START,
    input  logic          ABORT,
    output logic          DRIV,
    output logic          DRIV_SHIFT,
    output logic [4:0]    DRIV_FRONT,
    output logic [7:0]    DQ_OUT,
    output logic          BUSY,
    output logic          DONE,
    output logic [15:0]   ISSUED_CNT
);

    // Entry layout, MSB first: gap, reserved, last, shift, front, data.
    typedef struct packed {
        logic [7:0] gap;
        logic       rsvd;
        logic       last;
        logic       shift;
        logic [4:0] front;
        logic [7:0] dq;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    entry_t           table_reg [DEPTH];
    logic [DEPTH-1:0] row_we;
    logic             table_we;

    state_t           state_reg;
    logic [AW-1:0]    ptr_reg;
    logic [7:0]       loop_rem_reg;
    logic [7:0]       gap_cnt_reg;

    entry_t           cur_entry;
    entry_t           adv_entry;
    entry_t           start_entry;
    logic             at_end;
    logic             adv_fin;
    logic [AW-1:0]    adv_ptr;
    logic             do_advance;
    logic [15:0]      cnt_inc;

    // Table writes are locked out while a run is in progress.
    assign table_we = CFG_WE && !BUSY;

    // One write-enable per row.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row_we
            assign row_we[gi] = table_we && (CFG_ADDR == AW'(gi));
        end
    endgenerate

    // Table storage: flops cleared by reset so the table is known after power-up.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (row_we[i]) begin
                    table_reg[i] <= CFG_DATA;
                end
            end
        end
    end

    // Sequencing decisions: which entry issues next, and whether the run ends.
    always_comb begin
        cur_entry = table_reg[ptr_reg];
        at_end    = cur_entry.last || (ptr_reg == AW'(DEPTH - 1));
        adv_fin   = at_end && (loop_rem_reg == 8'd0);
        adv_ptr   = at_end ? '0 : ptr_reg + AW'(1);
        adv_entry = table_reg[adv_ptr];
        // A write to entry 0 in the START cycle must be seen by the first pulse.
        if (table_we && (CFG_ADDR == '0)) begin
            start_entry = CFG_DATA;
        end else begin
            start_entry = table_reg[0];
        end
        do_advance = ((state_reg == ST_ISSUE) && (cur_entry.gap == 8'd0)) ||
                     ((state_reg == ST_WAIT)  && (gap_cnt_reg == 8'd1));
        cnt_inc    = (ISSUED_CNT == 16'hFFFF) ? ISSUED_CNT : ISSUED_CNT + 16'd1;
    end

    // Run FSM with registered outputs. ABORT overrides everything except reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            loop_rem_reg <= '0;
            gap_cnt_reg  <= '0;
            DRIV         <= 1'b0;
            DRIV_SHIFT   <= 1'b0;
            DRIV_FRONT   <= '0;
            DQ_OUT       <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            ISSUED_CNT   <= '0;
        end else if (ABORT) begin
            // The pulse count is kept so the controller can see how far the run got.
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            loop_rem_reg <= '0;
            gap_cnt_reg  <= '0;
            DRIV         <= 1'b0;
            DRIV_SHIFT   <= 1'b0;
            DRIV_FRONT   <= '0;
            DQ_OUT       <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
        end else begin
            DRIV       <= 1'b0;
            DRIV_SHIFT <= 1'b0;
            DRIV_FRONT <= '0;
            DQ_OUT     <= '0;
            DONE       <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (START) begin
                        ptr_reg      <= '0;
                        loop_rem_reg <= LOOP_CNT;
                        ISSUED_CNT   <= 16'd1;
                        DRIV         <= 1'b1;
                        DRIV_SHIFT   <= start_entry.shift;
                        DRIV_FRONT   <= start_entry.front;
                        DQ_OUT       <= start_entry.dq;
                        BUSY         <= 1'b1;
                        state_reg    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gap_cnt_reg <= cur_entry.gap;
                    if (cur_entry.gap != 8'd0) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (gap_cnt_reg != 8'd1) begin
                        gap_cnt_reg <= gap_cnt_reg - 8'd1;
                    end
                end
                ST_FIN: begin
                    BUSY      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            // Leaving an entry: next pulse, next table pass, or completion.
            if (do_advance) begin
                if (adv_fin) begin
                    state_reg <= ST_FIN;
                    DONE      <= 1'b1;
                    BUSY      <= 1'b0;
                end else begin
                    if (at_end) begin
                        loop_rem_reg <= loop_rem_reg - 8'd1;
                    end
                    ptr_reg    <= adv_ptr;
                    DRIV       <= 1'b1;
                    DRIV_SHIFT <= adv_entry.shift;
                    DRIV_FRONT <= adv_entry.front;
                    DQ_OUT     <= adv_entry.dq;
                    ISSUED_CNT <= cnt_inc;
                    state_reg  <= ST_ISSUE;
                end
            end
        end
    end

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Programmable stimulus sequencer sitting directly upstream of the delayed-drive stage. It holds a small table of drive entries and, on START, replays them as single-cycle DRIV pulses. Each pulse carries its entry's DRIV_SHIFT, DRIV_FRONT and data fields, with a per-entry idle gap and an optional whole-table repeat count. A test controller loads the table, starts a run, and observes BUSY, DONE and a pulse count.

## Interface
- DEPTH, 16: number of table entries (power of two, 2..32).
- AW, 4: table address width, log2(DEPTH).
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- CFG_WE  in  1  table write strobe; ignored while BUSY=1.
- CFG_ADDR  in  AW  table write address.
- CFG_DATA  in  24  entry: [7:0] data, [12:8] front, [13] shift, [14] last, [15] reserved (stored, unused), [23:16] gap.
- LOOP_CNT  in  8  extra table repeats, sampled when START is accepted; the table plays LOOP_CNT+1 times.
- START  in  1  run request; accepted only in IDLE.
- ABORT  in  1  synchronous stop; has priority over START and over every state.
- DRIV  out  1  one-cycle drive pulse to the downstream stage.
- DRIV_SHIFT  out  1  entry shift bit; 0 whenever DRIV=0.
- DRIV_FRONT  out  5  entry front field; 0 whenever DRIV=0.
- DQ_OUT  out  8  entry data; 0 whenever DRIV=0.
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle pulse on normal completion.
- ISSUED_CNT  out  16  DRIV pulses issued since the last accepted START; saturates at 0xFFFF.

## Operation
- The table is DEPTH x 24 flops, cleared to zero by reset. It is written on the clock edge when CFG_WE=1 and BUSY=0.
- States:
  - IDLE: on START with ABORT=0, set ptr=0, latch loop_rem=LOOP_CNT, clear ISSUED_CNT, and go to ISSUE.
  - ISSUE: lasts one cycle. Drive DRIV=1 with the fields of entry[ptr]. Increment ISSUED_CNT, saturating at 0xFFFF. Load gap_cnt=entry.gap. If gap≠0, go to WAIT; otherwise apply ADVANCE.
  - WAIT: DRIV=0. Decrement gap_cnt each cycle. On the cycle gap_cnt reaches 1, apply ADVANCE.
  - ADVANCE (a decision, not a state):
    - End of table is entry.last=1 or ptr=DEPTH-1.
    - At end of table with loop_rem≠0: decrement loop_rem, set ptr=0, go to ISSUE.
    - At end of table with loop_rem=0: go to FIN.
    - Otherwise: increment ptr and go to ISSUE.
  - FIN: lasts one cycle. DONE=1, BUSY=0, then go to IDLE.
- BUSY is 1 in ISSUE and WAIT and 0 in IDLE and FIN.
- ABORT in any state forces IDLE on the next edge:
  - DRIV, DONE and BUSY go to 0.
  - ptr, loop_rem and gap_cnt are cleared.
  - ISSUED_CNT holds its value.
  - The table is untouched.
- START while BUSY=1 or in FIN is ignored.
- Entries past the first one with last=1 are never issued. A table with no last bit plays all DEPTH entries.
- All outputs are registered.

## Timing
- Reset values: DRIV=0, DRIV_SHIFT=0, DRIV_FRONT=0, DQ_OUT=0, BUSY=0, DONE=0, ISSUED_CNT=0; state IDLE; table all zero.
- START high in cycle 0 gives BUSY=1 and DRIV=1 (entry 0) in cycle 1.
- The DRIV of an entry with gap g is followed by the next DRIV exactly g+1 cycles later. With g=0, pulses fall on consecutive cycles.
- The final DRIV, in cycle t with gap g, is followed by DONE=1 and BUSY=0 in cycle t+g+1. The earliest new START is accepted in cycle t+g+2.
- Total pulses per run = (index of the first last-entry + 1) × (LOOP_CNT+1).
- ABORT high in cycle k gives DRIV=0 and BUSY=0 in cycle k+1. A pulse already on DRIV in cycle k still counts.
- A CFG_WE in the cycle START is accepted still writes, because BUSY is still 0. The ISSUE of entry 0 then reads the new value.

## Test plan
- Reset: assert RST_N=0 mid-run with DRIV=1 -> all outputs 0 immediately; after release, entry 0 reads 0x000000.
- Three entries {dq=0xA5, front=3, shift=1, gap=0}, {0x3C, front=0, shift=0, gap=2}, {0x7E, front=31, shift=1, last=1, gap=0}, LOOP_CNT=0, START in cycle 0 -> DRIV in cycles 1, 2 and 5 with matching fields; DONE in cycle 6; ISSUED_CNT=3.
- Same table with LOOP_CNT=2 -> 9 pulses; pattern period 5 cycles; DONE exactly once, after the ninth pulse; ISSUED_CNT=9.
- No last bit set, all gaps 0, DEPTH=16 -> 16 back-to-back DRIV pulses in cycles 1..16; DONE in cycle 17.
- ABORT in the cycle of the second pulse, with START also held high -> DRIV=0 and BUSY=0 next cycle; no DONE; ISSUED_CNT=2; the run does not restart.
- CFG_WE to entry 0 while BUSY=1, then START again after DONE -> the original entry 0 value is replayed; START during BUSY has no effect on pulse count.
